// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp classes,
// FSM states and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    // ALUOp class codes, decoded further by ALU_Control
    localparam logic [2:0] AluOpR    = 3'b111;
    localparam logic [2:0] AluOpAddi = 3'b100;
    localparam logic [2:0] AluOpOri  = 3'b101;
    localparam logic [2:0] AluOpAndi = 3'b001;
    localparam logic [2:0] AluOpLui  = 3'b110;
    localparam logic [2:0] AluOpAdd  = 3'b011;
    localparam logic [2:0] AluOpSub  = 3'b010;

    localparam logic [1:0] JmpCtlJr = 2'b10;

    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMdr = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] AluSrcBReg   = 2'b00;
    localparam logic [1:0] AluSrcBFour  = 2'b01;
    localparam logic [1:0] AluSrcBImm   = 2'b10;
    localparam logic [1:0] AluSrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcReg    = 2'b11;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StRWb, StExecI, StIWb, StMemAddr,
        StMemRead, StMemWb, StMemWrite, StBranch, StJump, StJr, StTrap
    } state_e;

    typedef enum logic [2:0] {
        ClsR, ClsI, ClsMem, ClsBranch, ClsJump, ClsIllegal
    } instr_class_e;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode decode: instruction class plus the ALUOp used by
// immediate-format arithmetic.
module opcode_class_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode_i,
    output instr_class_e instr_class_o,
    output logic [2:0]   alu_op_imm_o
);

    always_comb begin
        instr_class_o = ClsIllegal;
        alu_op_imm_o  = AluOpAdd;
        case (opcode_i)
            OpRType:      instr_class_o = ClsR;
            OpAddi: begin instr_class_o = ClsI; alu_op_imm_o = AluOpAddi; end
            OpOri:  begin instr_class_o = ClsI; alu_op_imm_o = AluOpOri;  end
            OpAndi: begin instr_class_o = ClsI; alu_op_imm_o = AluOpAndi; end
            OpLui:  begin instr_class_o = ClsI; alu_op_imm_o = AluOpLui;  end
            OpLw, OpSw:   instr_class_o = ClsMem;
            OpBeq, OpBne: instr_class_o = ClsBranch;
            OpJ, OpJal:   instr_class_o = ClsJump;
            default:      instr_class_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS datapath. Define ILLEGAL_OPCODE_TRAP_EN
// to trap unlisted opcodes (adds illegal_op_o) instead of treating them as NOPs.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode_i,
    input  logic [1:0]           jmp_ctl_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 pc_write_cond_o,
    output logic                 branch_ne_o,
    output logic                 i_or_d_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic [1:0]           mem_to_reg_o,
    output logic [1:0]           reg_dst_o,
    output logic                 reg_write_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           pc_source_o,
    output logic [2:0]           alu_op_o,
    output logic [CNT_WIDTH-1:0] instr_count_o
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic                 illegal_op_o
`endif
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    instr_class_e         instr_class;
    logic [2:0]           alu_op_imm;

    opcode_class_decoder u_decoder (
        .opcode_i      (opcode_i),
        .instr_class_o (instr_class),
        .alu_op_imm_o  (alu_op_imm)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                unique case (instr_class)
                    ClsR:      state_d = StExecR;
                    ClsI:      state_d = StExecI;
                    ClsMem:    state_d = StMemAddr;
                    ClsBranch: state_d = StBranch;
                    ClsJump:   state_d = StJump;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    default:   state_d = StTrap;
`else
                    default:   state_d = StFetch;
`endif
                endcase
            end
            StExecR:    state_d = (jmp_ctl_i == JmpCtlJr) ? StJr : StRWb;
            StExecI:    state_d = StIWb;
            StMemAddr:  state_d = (opcode_i == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready_i) state_d = StMemWb;
            StMemWrite: if (mem_ready_i) state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
        // Every return to FETCH retires one instruction; TRAP never returns
        cnt_d = cnt_q;
        if (state_d == StFetch && state_q != StFetch) cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = MemToRegAlu;
        reg_dst_o       = RegDstRt;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = AluSrcBReg;
        pc_source_o     = PcSrcAlu;
        alu_op_o        = AluOpAdd;
        unique case (state_q)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = AluSrcBFour;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            StDecode:   alu_src_b_o = AluSrcBImmSh;
            StExecR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = AluOpR;
            end
            StRWb: begin
                reg_dst_o   = RegDstRd;
                reg_write_o = 1'b1;
                alu_op_o    = AluOpR;
            end
            StExecI: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = AluSrcBImm;
                alu_op_o    = alu_op_imm;
            end
            StIWb: begin
                reg_write_o = 1'b1;
                alu_op_o    = alu_op_imm;
            end
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = AluSrcBImm;
            end
            StMemRead: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            StMemWb: begin
                mem_to_reg_o = MemToRegMdr;
                reg_write_o  = 1'b1;
            end
            StMemWrite: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            StBranch: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = AluOpSub;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PcSrcAluOut;
                branch_ne_o     = (opcode_i == OpBne);
            end
            StJump: begin
                pc_write_o  = 1'b1;
                pc_source_o = PcSrcJump;
                if (opcode_i == OpJal) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = RegDstRa;
                    mem_to_reg_o = MemToRegPc;
                end
            end
            StJr: begin
                pc_write_o  = 1'b1;
                pc_source_o = PcSrcReg;
            end
            default: ;
        endcase
    end

    assign instr_count_o = cnt_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign illegal_op_o = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed per-cycle expectations are
// queued by the driver and compared by a negedge monitor.
module tb_multicycle_control_unit;

    typedef enum int {
        SFetch, SDecode, SExecR, SRWb, SExecI, SIWb, SMemAddr,
        SMemRead, SMemWb, SMemWrite, SBranch, SJump, SJr, STrap
    } bst_e;

    typedef struct packed {
        logic       pcw, pwc, bne, iord, mr, mw, irw;
        logic [1:0] m2r, rd;
        logic       rw, asa;
        logic [1:0] asb, ps;
        logic [2:0] aop;
    } out_t;

    typedef struct packed {
        out_t        val;
        out_t        mask;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [1:0]  jmp_ctl = 2'd0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0]  mem_to_reg, reg_dst, alu_src_b, pc_source;
    logic        reg_write, alu_src_a;
    logic [2:0]  alu_op;
    logic [31:0] instr_count;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic        illegal_op;
`endif

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    multicycle_control_unit #(.CNT_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode_i        (opcode),
        .jmp_ctl_i       (jmp_ctl),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .branch_ne_o     (branch_ne),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .pc_source_o     (pc_source),
        .alu_op_o        (alu_op),
        .instr_count_o   (instr_count)
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ,
        .illegal_op_o    (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // Expected outputs per state; mux selects are only checked where they matter
    function automatic exp_t model(bst_e s, logic [5:0] op, logic rdy, logic [31:0] cnt);
        exp_t e;
        e = '0;
        e.cnt = cnt;
        e.mask.pcw = 1'b1; e.mask.pwc = 1'b1; e.mask.mr = 1'b1;
        e.mask.mw  = 1'b1; e.mask.irw = 1'b1; e.mask.rw = 1'b1;
        case (s)
            SFetch: begin
                e.mask = '1;
                e.val.mr = 1'b1; e.val.asb = 2'b01; e.val.aop = 3'b011;
                e.val.irw = rdy; e.val.pcw = rdy;
            end
            SDecode: begin
                e.mask.asa = 1'b1; e.mask.asb = 2'b11; e.mask.aop = 3'b111;
                e.val.asb = 2'b11; e.val.aop = 3'b011;
            end
            SExecR: begin
                e.mask.asa = 1'b1; e.mask.asb = 2'b11; e.mask.aop = 3'b111;
                e.val.asa = 1'b1; e.val.aop = 3'b111;
            end
            SRWb: begin
                e.mask.rd = 2'b11; e.mask.m2r = 2'b11; e.mask.aop = 3'b111;
                e.val.rw = 1'b1; e.val.rd = 2'b01; e.val.aop = 3'b111;
            end
            SExecI, SIWb: begin
                e.mask.aop = 3'b111;
                case (op)
                    6'b001000: e.val.aop = 3'b100;
                    6'b001101: e.val.aop = 3'b101;
                    6'b001100: e.val.aop = 3'b001;
                    default:   e.val.aop = 3'b110;
                endcase
                if (s == SExecI) begin
                    e.mask.asa = 1'b1; e.mask.asb = 2'b11;
                    e.val.asa = 1'b1; e.val.asb = 2'b10;
                end else begin
                    e.mask.rd = 2'b11; e.mask.m2r = 2'b11;
                    e.val.rw = 1'b1;
                end
            end
            SMemAddr: begin
                e.mask.asa = 1'b1; e.mask.asb = 2'b11; e.mask.aop = 3'b111;
                e.val.asa = 1'b1; e.val.asb = 2'b10; e.val.aop = 3'b011;
            end
            SMemRead: begin
                e.mask.iord = 1'b1; e.val.mr = 1'b1; e.val.iord = 1'b1;
            end
            SMemWb: begin
                e.mask.rd = 2'b11; e.mask.m2r = 2'b11;
                e.val.rw = 1'b1; e.val.m2r = 2'b01;
            end
            SMemWrite: begin
                e.mask.iord = 1'b1; e.val.mw = 1'b1; e.val.iord = 1'b1;
            end
            SBranch: begin
                e.mask.asa = 1'b1; e.mask.asb = 2'b11; e.mask.aop = 3'b111;
                e.mask.ps = 2'b11; e.mask.bne = 1'b1;
                e.val.asa = 1'b1; e.val.aop = 3'b010; e.val.pwc = 1'b1;
                e.val.ps = 2'b01; e.val.bne = (op == 6'b000101);
            end
            SJump: begin
                e.mask.ps = 2'b11; e.val.pcw = 1'b1; e.val.ps = 2'b10;
                if (op == 6'b000011) begin
                    e.mask.rd = 2'b11; e.mask.m2r = 2'b11;
                    e.val.rw = 1'b1; e.val.rd = 2'b10; e.val.m2r = 2'b10;
                end
            end
            SJr: begin
                e.mask.ps = 2'b11; e.val.pcw = 1'b1; e.val.ps = 2'b11;
            end
            STrap: e.ill = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(bst_e s, logic [5:0] op, logic rdy, logic [1:0] jmp, logic rst_v,
                        string nm);
        opcode = op; mem_ready = rdy; jmp_ctl = jmp; reset = rst_v;
        exp_q.push_back(model(s, op, rdy, exp_cnt));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_itype(logic [5:0] op, string nm);
        step(SFetch, op, 1'b1, 2'b00, 1'b0, nm);
        step(SDecode, op, 1'b1, 2'b00, 1'b0, nm);
        step(SExecI, op, 1'b1, 2'b00, 1'b0, nm);
        step(SIWb, op, 1'b1, 2'b00, 1'b0, nm);
        exp_cnt++;
    endtask

    task automatic run_3cyc(bst_e s, logic [5:0] op, string nm);
        step(SFetch, op, 1'b1, 2'b00, 1'b0, nm);
        step(SDecode, op, 1'b0, 2'b00, 1'b0, nm);
        step(s, op, 1'b1, 2'b00, 1'b0, nm);
        exp_cnt++;
    endtask

    exp_t  m_e;
    string m_nm;
    out_t  m_act;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e  = exp_q.pop_front();
            m_nm = name_q.pop_front();
            m_act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                     pc_source, alu_op};
            checks++;
            if (((m_act ^ m_e.val) & m_e.mask) != '0) begin
                errors++;
                $display("FAIL %s outputs: got %h want %h (mask %h) t=%0t", m_nm, m_act,
                         m_e.val, m_e.mask, $time);
            end
            checks++;
            if (instr_count !== m_e.cnt) begin
                errors++;
                $display("FAIL %s count: got %0d want %0d t=%0t", m_nm, instr_count,
                         m_e.cnt, $time);
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            checks++;
            if (illegal_op !== m_e.ill) begin
                errors++;
                $display("FAIL %s illegal_op: got %b want %b t=%0t", m_nm, illegal_op,
                         m_e.ill, $time);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(SFetch, 6'd0, 1'b0, 2'b00, 1'b1, "reset");

        run_itype(6'b001000, "addi");

        // Fetch wait states, then ORI; mem_ready low in DECODE is ignored
        step(SFetch, 6'b001101, 1'b0, 2'b00, 1'b0, "fetch_wait");
        step(SFetch, 6'b001101, 1'b0, 2'b00, 1'b0, "fetch_wait");
        step(SFetch, 6'b001101, 1'b1, 2'b00, 1'b0, "ori");
        step(SDecode, 6'b001101, 1'b0, 2'b00, 1'b0, "ori");
        step(SExecI, 6'b001101, 1'b0, 2'b00, 1'b0, "ori");
        step(SIWb, 6'b001101, 1'b0, 2'b00, 1'b0, "ori");
        exp_cnt++;

        run_itype(6'b001100, "andi");
        run_itype(6'b001111, "lui");

        // LW with three wait states in MEM_READ: 8 cycles
        step(SFetch, 6'b100011, 1'b1, 2'b00, 1'b0, "lw");
        step(SDecode, 6'b100011, 1'b1, 2'b00, 1'b0, "lw");
        step(SMemAddr, 6'b100011, 1'b1, 2'b00, 1'b0, "lw");
        for (int i = 0; i < 3; i++) step(SMemRead, 6'b100011, 1'b0, 2'b00, 1'b0, "lw_wait");
        step(SMemRead, 6'b100011, 1'b1, 2'b00, 1'b0, "lw");
        step(SMemWb, 6'b100011, 1'b1, 2'b00, 1'b0, "lw");
        exp_cnt++;

        run_3cyc(SBranch, 6'b000101, "bne");
        run_3cyc(SBranch, 6'b000100, "beq");

        // JR via R-type with jmp_ctl = 2'b10
        step(SFetch, 6'b000000, 1'b1, 2'b00, 1'b0, "jr");
        step(SDecode, 6'b000000, 1'b1, 2'b00, 1'b0, "jr");
        step(SExecR, 6'b000000, 1'b1, 2'b10, 1'b0, "jr");
        step(SJr, 6'b000000, 1'b1, 2'b10, 1'b0, "jr");
        exp_cnt++;

        step(SFetch, 6'b000000, 1'b1, 2'b00, 1'b0, "rtype");
        step(SDecode, 6'b000000, 1'b1, 2'b00, 1'b0, "rtype");
        step(SExecR, 6'b000000, 1'b1, 2'b00, 1'b0, "rtype");
        step(SRWb, 6'b000000, 1'b1, 2'b00, 1'b0, "rtype");
        exp_cnt++;

        run_3cyc(SJump, 6'b000011, "jal");
        run_3cyc(SJump, 6'b000010, "j");

        // SW interrupted by reset while waiting in MEM_WRITE
        step(SFetch, 6'b101011, 1'b1, 2'b00, 1'b0, "sw");
        step(SDecode, 6'b101011, 1'b1, 2'b00, 1'b0, "sw");
        step(SMemAddr, 6'b101011, 1'b1, 2'b00, 1'b0, "sw");
        step(SMemWrite, 6'b101011, 1'b0, 2'b00, 1'b0, "sw_wait");
        exp_cnt = 0;
        step(SFetch, 6'b101011, 1'b0, 2'b00, 1'b1, "rst_in_memwrite");
        step(SFetch, 6'b101011, 1'b0, 2'b00, 1'b0, "after_rst");
        run_itype(6'b001000, "addi_after_rst");

        // Unlisted opcode
        step(SFetch, 6'b111111, 1'b1, 2'b00, 1'b0, "illegal");
        step(SDecode, 6'b111111, 1'b1, 2'b00, 1'b0, "illegal");
`ifdef ILLEGAL_OPCODE_TRAP_EN
        for (int i = 0; i < 3; i++) step(STrap, 6'b000000, 1'b1, 2'b00, 1'b0, "trap");
        exp_cnt = 0;
        step(SFetch, 6'b000000, 1'b0, 2'b00, 1'b1, "trap_reset");
        step(SFetch, 6'b000000, 1'b0, 2'b00, 1'b0, "trap_reset");
`else
        exp_cnt++;
        step(SFetch, 6'b111111, 1'b0, 2'b00, 1'b0, "nop_retired");
`endif
        run_itype(6'b001111, "lui_final");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
